operand_read_stage: RTL and testbench
=====================================

# operand_read_stage

Register-read stage of the in-order RV32I core. It sits between decode and execute, owns the 32×32 integer register file, and accepts that file's single write port from the writeback stage. It tracks outstanding destination registers in a scoreboard and stalls on RAW/WAW hazards. Operands are presented to execute through a registered valid/ready output slot.

## Interface
- SP_INIT, 1000, reset value of x2 (stack pointer); every other register resets to 0
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  32  instruction PC
- in_rs1, in_rs2  in  5 each  source register indices
- in_uses_rs1, in_uses_rs2  in  1 each  the source is actually read
- in_rd  in  5  destination index
- in_rd_wen  in  1  instruction writes rd
- wb_wen  in  1  writeback write enable
- wb_addr  in  5  writeback destination
- wb_data  in  32  writeback value
- flush  in  1  kill the instruction held in the output slot
- out_valid  out  1  output slot occupied
- out_ready  in  1  execute consumes the slot
- out_pc, out_rs1_data, out_rs2_data  out  32 each  captured PC and operands
- out_rd  out  5; out_rd_wen  out  1  forwarded destination info

## Operation
- Register file writes:
  - wb_wen=1 with wb_addr≠0 writes wb_data at the clk edge.
  - Writes to x0 are dropped. Reads of x0 always return 0.
- Scoreboard busy[31:1]; busy[0] is constant 0.
  - Set: on accept with in_rd_wen=1 and in_rd≠0, busy[in_rd] is set.
  - Clear: wb_wen=1 with wb_addr≠0 clears busy[wb_addr].
  - Same index set and cleared in one cycle: set wins.
- Bypass: when wb_wen=1, wb_addr≠0 and wb_addr equals a source, that operand reads wb_data and is not a hazard this cycle.
- Hazard conditions:
  - RAW: (in_uses_rs1 and busy[in_rs1] and no bypass on rs1), or the same condition on rs2.
  - WAW: in_rd_wen and in_rd≠0 and busy[in_rd] and not cleared by wb this cycle.
- Handshake:
  - in_ready = !hazard & !flush & (!out_valid | out_ready).
  - Accept = in_valid & in_ready.
- Accept loads the output slot: out_valid←1, and out_pc, operands, out_rd and out_rd_wen are captured.
- Output hold:
  - out_valid & !out_ready holds the slot stable.
  - out_valid & out_ready with no accept clears out_valid.
- Flush:
  - Clears out_valid.
  - If the held instruction has out_rd_wen=1 and out_rd≠0, its busy bit is cleared, unless wb clears it in the same cycle (harmless).
  - No accept occurs while flush=1.
  - Instructions already past this stage are unaffected.

## Timing
- Reset (async, rst_n=0):
  - Outputs: out_valid=0, out_pc=0, out_rs1_data=0, out_rs2_data=0, out_rd=0, out_rd_wen=0.
  - State: busy=0; regfile x2=SP_INIT, all others 0.
- A reset asserted mid-operation discards the output slot and all scoreboard state immediately.
- Latency is 1 cycle: accept at edge N, out_valid high after edge N.
- in_ready is combinational from the in_* signals, wb_*, flush, out_valid and out_ready. out_* depend on registers only.
- Throughput is 1 instruction/cycle with no hazards and out_ready=1.
- RAW on a pending write: in_ready goes high in the same cycle that the matching wb_wen arrives (bypass). There is no extra bubble.
- Operands are captured at accept. Later writebacks do not alter out_rs*_data.

## Test plan
- Reset then read: rst_n low→high, issue rs1=2, rs2=0 → out_rs1_data=1000, out_rs2_data=0 one cycle after accept.
- Back-to-back RAW:
  - Issue "x5 := …" (rd=5, wen=1), then an instruction with rs1=5 → in_ready=0 until wb_wen=1, wb_addr=5, wb_data=0xDEADBEEF.
  - Accept occurs in that same cycle with out_rs1_data=0xDEADBEEF.
- WAW: two issues with rd=7 → second stalls until wb_addr=7 arrives, then accepts; busy[7] remains set afterwards.
- x0 handling: wb_wen=1, wb_addr=0, wb_data=0x1234, then read rs1=0 → out_rs1_data=0, and rd=0 never stalls.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → out_* stable, in_ready=0; release → drains one per cycle.
- Flush: held instruction rd=9 with out_ready=0, assert flush → out_valid=0 next cycle, and a following rs1=9 instruction accepts immediately reading the old x9 value.

Source files
------------

// File: rtl/operand_read_stage_if.sv
// Decode/writeback/execute-facing signals of the register-read stage.
// The master drives decoded instructions, writeback and control; the slave is the stage.
interface operand_read_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_uses_rs1;
  logic        in_uses_rs2;
  logic [4:0]  in_rd;
  logic        in_rd_wen;

  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        flush;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_wen;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_rd, in_rd_wen,
    output wb_wen, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_rd, out_rd_wen
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_rd, in_rd_wen,
    input  wb_wen, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_rd, out_rd_wen
  );
endinterface

// File: rtl/operand_read_stage.sv
// RV32I register-read stage: 32x32 register file, busy scoreboard with RAW/WAW stalls,
// writeback bypass, and a registered valid/ready output slot toward execute.
module operand_read_stage #(
  parameter logic [31:0] SP_INIT = 32'd1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_read_stage_if.slave  bus
);

  logic [31:0] r_rf [32];
  logic [31:1] r_busy;

  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_rs1_data;
  logic [31:0] r_out_rs2_data;
  logic [4:0]  r_out_rd;
  logic        r_out_rd_wen;

  logic        w_wb_we;
  logic [31:0] w_busy;
  logic        w_byp_rs1;
  logic        w_byp_rs2;
  logic        w_raw;
  logic        w_rd_live;
  logic        w_waw;
  logic        w_ready;
  logic        w_accept;
  logic        w_kill;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [31:1] w_busy_next;

  assign w_wb_we = bus.wb_wen && (bus.wb_addr != 5'd0);
  assign w_busy  = {r_busy, 1'b0};

  // A writeback landing this cycle satisfies a pending read directly.
  assign w_byp_rs1 = w_wb_we && (bus.wb_addr == bus.in_rs1);
  assign w_byp_rs2 = w_wb_we && (bus.wb_addr == bus.in_rs2);

  assign w_raw = (bus.in_uses_rs1 && w_busy[bus.in_rs1] && !w_byp_rs1)
              || (bus.in_uses_rs2 && w_busy[bus.in_rs2] && !w_byp_rs2);

  assign w_rd_live = bus.in_rd_wen && (bus.in_rd != 5'd0);
  assign w_waw     = w_rd_live && w_busy[bus.in_rd]
                  && !(w_wb_we && (bus.wb_addr == bus.in_rd));

  assign w_ready  = !w_raw && !w_waw && !bus.flush && (!r_out_valid || bus.out_ready);
  assign w_accept = bus.in_valid && w_ready;

  assign w_kill = bus.flush && r_out_valid && r_out_rd_wen && (r_out_rd != 5'd0);

  assign w_rs1_data = w_byp_rs1 ? bus.wb_data
                    : ((bus.in_rs1 == 5'd0) ? 32'd0 : r_rf[bus.in_rs1]);
  assign w_rs2_data = w_byp_rs2 ? bus.wb_data
                    : ((bus.in_rs2 == 5'd0) ? 32'd0 : r_rf[bus.in_rs2]);

  // Per-bit scoreboard update; a set from a new accept overrides any clear.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      assign w_busy_next[gi] =
          (w_accept && w_rd_live && (bus.in_rd == 5'(gi)))
       || (r_busy[gi]
           && !(w_wb_we && (bus.wb_addr == 5'(gi)))
           && !(w_kill && (r_out_rd == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= (i == 2) ? SP_INIT : 32'd0;
      end
    end else if (w_wb_we) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= 32'd0;
      r_out_rs1_data <= 32'd0;
      r_out_rs2_data <= 32'd0;
      r_out_rd       <= 5'd0;
      r_out_rd_wen   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_pc       <= bus.in_pc;
      r_out_rs1_data <= w_rs1_data;
      r_out_rs2_data <= w_rs2_data;
      r_out_rd       <= bus.in_rd;
      r_out_rd_wen   <= bus.in_rd_wen;
    end else if (bus.flush || bus.out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  assign bus.in_ready     = w_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_pc       = r_out_pc;
  assign bus.out_rs1_data = r_out_rs1_data;
  assign bus.out_rs2_data = r_out_rs2_data;
  assign bus.out_rd       = r_out_rd;
  assign bus.out_rd_wen   = r_out_rd_wen;

endmodule

// File: tb/tb_operand_read_stage.sv
// Directed scenarios plus randomized traffic against a register/scoreboard/slot reference model.
module tb_operand_read_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_read_stage_if bus();

  operand_read_stage #(.SP_INIT(32'd1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf [32];
  bit          m_busy [32];
  bit          m_v;
  logic [31:0] m_pc, m_d1, m_d2;
  logic [4:0]  m_rd;
  bit          m_rdwen;
  logic        last_ready;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = (r == 2) ? 32'd1000 : 32'd0;
      m_busy[r] = 1'b0;
    end
    m_v = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_rd = '0; m_rdwen = 1'b0;
  endfunction

  function automatic bit written_now(logic [4:0] r);
    return bus.wb_wen && (r != 5'd0) && (bus.wb_addr == r);
  endfunction

  // A register is a hazard only if its producer is outstanding and not retiring right now.
  function automatic bit pending(logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !written_now(r);
  endfunction

  function automatic logic [31:0] read_src(logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (written_now(r)) return bus.wb_data;
    return m_rf[r];
  endfunction

  function automatic bit model_ready();
    bit stall;
    stall = (bus.in_uses_rs1 && pending(bus.in_rs1))
         || (bus.in_uses_rs2 && pending(bus.in_rs2))
         || (bus.in_rd_wen && pending(bus.in_rd));
    return !stall && !bus.flush && (!m_v || bus.out_ready);
  endfunction

  task automatic step();
    bit          exp_rdy, acc;
    logic [31:0] v1, v2;
    #2;
    exp_rdy    = model_ready();
    last_ready = bus.in_ready;
    check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    v1  = read_src(bus.in_rs1);
    v2  = read_src(bus.in_rs2);
    @(posedge clk);
    if (bus.wb_wen && bus.wb_addr != 5'd0) begin
      m_rf[bus.wb_addr]   = bus.wb_data;
      m_busy[bus.wb_addr] = 1'b0;
    end
    if (bus.flush && m_v && m_rdwen && m_rd != 5'd0) m_busy[m_rd] = 1'b0;
    if (acc) begin
      if (bus.in_rd_wen && bus.in_rd != 5'd0) m_busy[bus.in_rd] = 1'b1;
      m_v = 1'b1; m_pc = bus.in_pc; m_d1 = v1; m_d2 = v2;
      m_rd = bus.in_rd; m_rdwen = bus.in_rd_wen;
      $display("accept pc=%h rs1=%0d:%h rs2=%0d:%h rd=%0d wen=%0d",
               m_pc, bus.in_rs1, v1, bus.in_rs2, v2, m_rd, m_rdwen);
    end else if (bus.flush || bus.out_ready) begin
      m_v = 1'b0;
    end
    #1;
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_v));
    if (m_v) begin
      check_eq("out_pc", bus.out_pc, m_pc);
      check_eq("out_rs1_data", bus.out_rs1_data, m_d1);
      check_eq("out_rs2_data", bus.out_rs2_data, m_d2);
      check_eq("out_rd", 32'(bus.out_rd), 32'(m_rd));
      check_eq("out_rd_wen", 32'(bus.out_rd_wen), 32'(m_rdwen));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_uses_rs1 = 1'b0; bus.in_uses_rs2 = 1'b0;
    bus.in_rd_wen = 1'b0; bus.wb_wen = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic drive_instr(logic [31:0] pc, logic [4:0] rs1, logic u1,
                             logic [4:0] rs2, logic u2, logic [4:0] rd, logic rdwen);
    bus.in_valid = 1'b1; bus.in_pc = pc;
    bus.in_rs1 = rs1; bus.in_uses_rs1 = u1;
    bus.in_rs2 = rs2; bus.in_uses_rs2 = u2;
    bus.in_rd = rd; bus.in_rd_wen = rdwen;
  endtask

  task automatic set_wb(logic en, logic [4:0] addr, logic [31:0] data);
    bus.wb_wen = en; bus.wb_addr = addr; bus.wb_data = data;
  endtask

  task automatic random_cycle();
    int q[$];
    drive_instr($urandom, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7));
    bus.in_valid = ($urandom_range(0, 9) < 8);
    for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
    bus.wb_wen  = ($urandom_range(0, 9) < 4);
    bus.wb_data = $urandom;
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      bus.wb_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
    else
      bus.wb_addr = 5'($urandom_range(0, 7));
    bus.flush     = ($urandom_range(0, 19) == 0);
    bus.out_ready = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    set_wb(1'b0, 5'd0, 32'd0);
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_pc", bus.out_pc, 32'd0);
    check_eq("rst_out_rs1", bus.out_rs1_data, 32'd0);
    check_eq("rst_out_rs2", bus.out_rs2_data, 32'd0);
    check_eq("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check_eq("rst_out_rd_wen", 32'(bus.out_rd_wen), 32'd0);
    rst_n = 1'b1;

    // Stack pointer reset value and x0 read.
    drive_instr(32'h100, 5'd2, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    step();
    check_eq("sp_read_rs1", bus.out_rs1_data, 32'd1000);
    check_eq("sp_read_rs2", bus.out_rs2_data, 32'd0);
    idle(); step();

    // RAW on x5 resolved by same-cycle bypass.
    drive_instr(32'h104, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    step();
    drive_instr(32'h108, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step(); check_eq("raw_stall_a", 32'(last_ready), 32'd0);
    step(); check_eq("raw_stall_b", 32'(last_ready), 32'd0);
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    check_eq("raw_bypass_ready", 32'(last_ready), 32'd1);
    check_eq("raw_bypass_data", bus.out_rs1_data, 32'hDEADBEEF);
    set_wb(1'b0, 5'd0, 32'd0);

    // WAW on x7; busy stays set by the second writer.
    drive_instr(32'h10C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    step();
    step(); check_eq("waw_stall", 32'(last_ready), 32'd0);
    set_wb(1'b1, 5'd7, 32'h77);
    step(); check_eq("waw_release", 32'(last_ready), 32'd1);
    set_wb(1'b0, 5'd0, 32'd0);
    drive_instr(32'h110, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step(); check_eq("waw_busy_kept", 32'(last_ready), 32'd0);
    set_wb(1'b1, 5'd7, 32'h78);
    step(); check_eq("waw_read_data", bus.out_rs1_data, 32'h78);
    set_wb(1'b0, 5'd0, 32'd0);

    // x0 writes dropped; rd=0 never stalls.
    set_wb(1'b1, 5'd0, 32'h1234);
    drive_instr(32'h114, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    step(); check_eq("x0_ready_a", 32'(last_ready), 32'd1);
    check_eq("x0_read", bus.out_rs1_data, 32'd0);
    step(); check_eq("x0_ready_b", 32'(last_ready), 32'd1);
    set_wb(1'b0, 5'd0, 32'd0);

    // Backpressure holds the slot, then drains one per cycle.
    idle(); step();
    bus.out_ready = 1'b0;
    drive_instr(32'h200, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    step();
    for (int k = 1; k <= 3; k++) begin
      bus.in_pc = 32'h200 + 32'(4 * k);
      step();
      check_eq("bp_stall", 32'(last_ready), 32'd0);
      check_eq("bp_hold_pc", bus.out_pc, 32'h200);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_pc = 32'h300 + 32'(4 * k);
      step();
      check_eq("bp_drain_ready", 32'(last_ready), 32'd1);
      check_eq("bp_drain_pc", bus.out_pc, 32'h300 + 32'(4 * k));
    end

    // Flush kills held rd=9 writer; reader then sees old x9.
    idle(); set_wb(1'b1, 5'd9, 32'h9999); step();
    set_wb(1'b0, 5'd0, 32'd0);
    bus.out_ready = 1'b0;
    drive_instr(32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    step();
    bus.flush = 1'b1;
    drive_instr(32'h404, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    check_eq("flush_no_accept", 32'(last_ready), 32'd0);
    check_eq("flush_clears_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    step();
    check_eq("flush_reader_ready", 32'(last_ready), 32'd1);
    check_eq("flush_reader_data", bus.out_rs1_data, 32'h9999);

    // Asynchronous reset mid-operation.
    bus.out_ready = 1'b0;
    drive_instr(32'h500, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("async_rst_pc", bus.out_pc, 32'd0);
    check_eq("async_rst_busy", 32'(bus.in_ready), 32'd1);
    model_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      random_cycle();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
